// File: rtl/atm_session_engine_if.sv
// Bundled card/PIN/operation/configuration signals for atm_session_engine.
// The master is the user-interface side; the slave is the session engine.
interface atm_session_engine_if #(
  parameter int P_WIDTH = 16,
  parameter int B_WIDTH = 20,
  parameter int C_WIDTH = 6
);
  logic               card_in;
  logic [C_WIDTH-1:0] card_number;
  logic               pin_valid;
  logic [P_WIDTH-1:0] pin_in;
  logic               op_valid;
  logic [1:0]         op;
  logic [B_WIDTH-1:0] amount;
  logic               another_service;
  logic               cancel;
  logic               cfg_we;
  logic [C_WIDTH-1:0] cfg_addr;
  logic [P_WIDTH-1:0] cfg_pin;
  logic [B_WIDTH-1:0] cfg_balance;

  logic               card_out;
  logic [B_WIDTH-1:0] balance_out;
  logic               op_done;
  logic               error;
  logic [2:0]         err_code;
  logic               wrong_password;
  logic               busy;

  modport master (
    output card_in, card_number, pin_valid, pin_in, op_valid, op, amount,
           another_service, cancel, cfg_we, cfg_addr, cfg_pin, cfg_balance,
    input  card_out, balance_out, op_done, error, err_code, wrong_password, busy
  );

  modport slave (
    input  card_in, card_number, pin_valid, pin_in, op_valid, op, amount,
           another_service, cancel, cfg_we, cfg_addr, cfg_pin, cfg_balance,
    output card_out, balance_out, op_done, error, err_code, wrong_password, busy
  );
endinterface

// File: rtl/atm_session_engine.sv
// ATM session engine: account table, PIN check with lockout, service loop, eject.
// Optional per-session withdrawal cap enabled by defining ATM_DAILY_LIMIT_EN.
module atm_session_engine #(
  parameter int P_WIDTH        = 16,
  parameter int B_WIDTH        = 20,
  parameter int C_WIDTH        = 6,
  parameter int ACCOUNTS       = 8,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DAILY_LIMIT    = 5000
) (
  input logic                clk,
  input logic                rst,
  atm_session_engine_if.slave bus
);

  localparam int A_W  = (ACCOUNTS > 1) ? $clog2(ACCOUNTS) : 1;
  localparam int T_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TR_W = $clog2(MAX_TRIES + 1);

  localparam logic [T_W-1:0]  T_LAST   = T_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TR_W-1:0] TRY_LAST = TR_W'(MAX_TRIES - 1);

  localparam logic [2:0] E_INVALID = 3'd1;
  localparam logic [2:0] E_LOCKED  = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_FUNDS   = 3'd4;
  localparam logic [2:0] E_OVF     = 3'd5;
  localparam logic [2:0] E_BAD_OP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_MENU, S_EXEC, S_ASK, S_EJECT
  } state_t;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_RESERVED = 2'b11
  } op_t;

  generate
    if (ACCOUNTS > 2 ** C_WIDTH) begin : g_bad_accounts
      $error("ACCOUNTS exceeds the card number space");
    end
    if (DAILY_LIMIT >= 2 ** B_WIDTH) begin : g_bad_limit
      $error("DAILY_LIMIT does not fit in B_WIDTH");
    end
  endgenerate

  logic [P_WIDTH-1:0] pin_mem  [ACCOUNTS];
  logic [B_WIDTH-1:0] bal_mem  [ACCOUNTS];
  logic               lock_mem [ACCOUNTS];

  state_t             state;
  logic [A_W-1:0]     cur_idx;
  logic [TR_W-1:0]    tries;
  logic [T_W-1:0]     timer;
  op_t                op_r;
  logic [B_WIDTH-1:0] amt_r;

  logic               card_ok;
  logic               cfg_ok;
  logic [A_W-1:0]     card_idx;
  logic [A_W-1:0]     cfg_idx;
  logic [B_WIDTH-1:0] bal_cur;
  logic [B_WIDTH:0]   dep_sum;
  logic               timed_out;

  assign card_ok   = {1'b0, bus.card_number} < (C_WIDTH + 1)'(ACCOUNTS);
  assign cfg_ok    = {1'b0, bus.cfg_addr} < (C_WIDTH + 1)'(ACCOUNTS);
  assign card_idx  = bus.card_number[A_W-1:0];
  assign cfg_idx   = bus.cfg_addr[A_W-1:0];
  assign bal_cur   = bal_mem[cur_idx];
  assign dep_sum   = {1'b0, bal_cur} + {1'b0, amt_r};
  assign timed_out = (timer == T_LAST);

`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [2:0] E_LIMIT = 3'd6;
  logic [B_WIDTH-1:0] acc;
  logic [B_WIDTH:0]   acc_sum;
  assign acc_sum = {1'b0, acc} + {1'b0, amt_r};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the account table is reset like any other state, so a fresh
      // chip has zeroed, unlocked entries; this keeps it in flops, not SRAM.
      for (int i = 0; i < ACCOUNTS; i++) begin
        pin_mem[i]  <= '0;
        bal_mem[i]  <= '0;
        lock_mem[i] <= 1'b0;
      end
      state              <= S_IDLE;
      cur_idx            <= '0;
      tries              <= '0;
      timer              <= '0;
      op_r               <= OP_BALANCE;
      amt_r              <= '0;
      bus.card_out       <= 1'b0;
      bus.balance_out    <= '0;
      bus.op_done        <= 1'b0;
      bus.error          <= 1'b0;
      bus.err_code       <= '0;
      bus.wrong_password <= 1'b0;
      bus.busy           <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
      acc                <= '0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignment so every read in this
      // block sees the pre-edge value regardless of statement order.
      bus.op_done        <= 1'b0;
      bus.error          <= 1'b0;
      bus.wrong_password <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.cfg_we && cfg_ok) begin
            pin_mem[cfg_idx]  <= bus.cfg_pin;
            bal_mem[cfg_idx]  <= bus.cfg_balance;
            lock_mem[cfg_idx] <= 1'b0;
          end
          if (bus.card_in) begin
            bus.busy <= 1'b1;
            timer    <= '0;
            cur_idx  <= card_idx;
            if (!card_ok) begin
              bus.error    <= 1'b1;
              bus.err_code <= E_INVALID;
              bus.card_out <= 1'b1;
              state        <= S_EJECT;
            end else if (lock_mem[card_idx]) begin
              bus.error    <= 1'b1;
              bus.err_code <= E_LOCKED;
              bus.card_out <= 1'b1;
              state        <= S_EJECT;
            end else begin
              tries        <= '0;
              bus.err_code <= '0;
              state        <= S_PIN;
            end
          end
        end

        S_PIN: begin
          if (bus.cancel) begin
            bus.card_out <= 1'b1;
            timer        <= '0;
            state        <= S_EJECT;
          end else if (bus.pin_valid) begin
            timer <= '0;
            if (bus.pin_in == pin_mem[cur_idx]) begin
              state <= S_MENU;
            end else begin
              bus.wrong_password <= 1'b1;
              tries              <= tries + 1'b1;
              if (tries == TRY_LAST) begin
                lock_mem[cur_idx] <= 1'b1;
                bus.error         <= 1'b1;
                bus.err_code      <= E_LOCKED;
                bus.card_out      <= 1'b1;
                state             <= S_EJECT;
              end
            end
          end else if (timed_out) begin
            bus.error    <= 1'b1;
            bus.err_code <= E_TIMEOUT;
            bus.card_out <= 1'b1;
            timer        <= '0;
            state        <= S_EJECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_MENU: begin
          if (bus.cancel) begin
            bus.card_out <= 1'b1;
            timer        <= '0;
            state        <= S_EJECT;
          end else if (bus.op_valid) begin
            op_r  <= op_t'(bus.op);
            amt_r <= bus.amount;
            timer <= '0;
            state <= S_EXEC;
          end else if (timed_out) begin
            bus.error    <= 1'b1;
            bus.err_code <= E_TIMEOUT;
            bus.card_out <= 1'b1;
            timer        <= '0;
            state        <= S_EJECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_EXEC: begin
          timer           <= '0;
          state           <= S_ASK;
          bus.balance_out <= bal_cur;
          unique case (op_r)
            OP_BALANCE: bus.op_done <= 1'b1;
            OP_WITHDRAW: begin
              if (amt_r > bal_cur) begin
                bus.error    <= 1'b1;
                bus.err_code <= E_FUNDS;
`ifdef ATM_DAILY_LIMIT_EN
              end else if (acc_sum > (B_WIDTH + 1)'(DAILY_LIMIT)) begin
                bus.error    <= 1'b1;
                bus.err_code <= E_LIMIT;
`endif
              end else begin
                bal_mem[cur_idx] <= bal_cur - amt_r;
                bus.balance_out  <= bal_cur - amt_r;
                bus.op_done      <= 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
                acc              <= acc_sum[B_WIDTH-1:0];
`endif
              end
            end
            OP_DEPOSIT: begin
              // Carry out of the widened sum means the balance would wrap.
              if (dep_sum[B_WIDTH]) begin
                bus.error    <= 1'b1;
                bus.err_code <= E_OVF;
              end else begin
                bal_mem[cur_idx] <= dep_sum[B_WIDTH-1:0];
                bus.balance_out  <= dep_sum[B_WIDTH-1:0];
                bus.op_done      <= 1'b1;
              end
            end
            OP_RESERVED: begin
              bus.error    <= 1'b1;
              bus.err_code <= E_BAD_OP;
            end
            default: ;
          endcase
        end

        S_ASK: begin
          if (bus.cancel) begin
            bus.card_out <= 1'b1;
            timer        <= '0;
            state        <= S_EJECT;
          end else if (bus.another_service) begin
            timer <= '0;
            state <= S_MENU;
          end else if (timed_out) begin
            bus.error    <= 1'b1;
            bus.err_code <= E_TIMEOUT;
            bus.card_out <= 1'b1;
            timer        <= '0;
            state        <= S_EJECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_EJECT: begin
          if (!bus.card_in) begin
            bus.card_out <= 1'b0;
            bus.busy     <= 1'b0;
            tries        <= '0;
            timer        <= '0;
`ifdef ATM_DAILY_LIMIT_EN
            acc          <= '0;
`endif
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_engine.sv
// Scoreboard bench for atm_session_engine: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_atm_session_engine;

  localparam int P_W = 16;
  localparam int B_W = 20;
  localparam int C_W = 6;
  localparam int TO  = 40;

  typedef struct {
    logic [2:0]     flags;  // {op_done, error, wrong_password}
    logic [2:0]     code;
    logic [B_W-1:0] bal;
    logic           chk_bal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  atm_session_engine_if #(.P_WIDTH(P_W), .B_WIDTH(B_W), .C_WIDTH(C_W)) bus ();

  atm_session_engine #(
    .P_WIDTH(P_W), .B_WIDTH(B_W), .C_WIDTH(C_W), .ACCOUNTS(8),
    .MAX_TRIES(3), .TIMEOUT_CYCLES(TO), .DAILY_LIMIT(5000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] flags, input logic [2:0] code,
                           input logic [B_W-1:0] bal, input logic chk_bal);
    exp_t e;
    e.flags = flags; e.code = code; e.bal = bal; e.chk_bal = chk_bal;
    sb.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && (bus.op_done || bus.error || bus.wrong_password)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'd0, bus.op_done, bus.error, bus.wrong_password}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_flags", {29'd0, bus.op_done, bus.error, bus.wrong_password}, {29'd0, e.flags});
        if (e.flags[1]) check("event_err_code", {29'd0, bus.err_code}, {29'd0, e.code});
        if (e.chk_bal)  check("event_balance", {12'd0, bus.balance_out}, {12'd0, e.bal});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [C_W-1:0] a, input logic [P_W-1:0] p, input logic [B_W-1:0] b);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_pin = p; bus.cfg_balance = b;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic insert(input logic [C_W-1:0] c);
    @(negedge clk);
    bus.card_in = 1'b1; bus.card_number = c;
  endtask

  task automatic remove_card();
    @(negedge clk);
    bus.card_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic enter_pin(input logic [P_W-1:0] p);
    @(negedge clk);
    bus.pin_valid = 1'b1; bus.pin_in = p;
    @(negedge clk);
    bus.pin_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [B_W-1:0] a);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = o; bus.amount = a;
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_another();
    @(negedge clk);
    bus.another_service = 1'b1;
    @(negedge clk);
    bus.another_service = 1'b0;
  endtask

  task automatic press_cancel();
    @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.card_in = 0; bus.card_number = '0; bus.pin_valid = 0; bus.pin_in = '0;
    bus.op_valid = 0; bus.op = '0; bus.amount = '0; bus.another_service = 0;
    bus.cancel = 0; bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_pin = '0;
    bus.cfg_balance = '0;
    idle(3);
    rst = 1'b1;
    idle(1);
    check("reset_card_out", {31'd0, bus.card_out}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_balance_out", {12'd0, bus.balance_out}, 32'd0);
    check("reset_err_code", {29'd0, bus.err_code}, 32'd0);

    // Normal withdraw then cancel; card_out holds until card removed.
    cfg_write(6'd2, 16'h1234, 20'd1000);
    insert(6'd2);
    idle(1);
    check("session_busy", {31'd0, bus.busy}, 32'd1);
    enter_pin(16'h1234);
    expect_ev(3'b100, 3'd0, 20'd700, 1'b1);
    do_op(2'b01, 20'd300);
    check("withdraw_balance_out", {12'd0, bus.balance_out}, 32'd700);
    press_cancel();
    check("cancel_card_out", {31'd0, bus.card_out}, 32'd1);
    idle(4);
    check("card_out_held", {31'd0, bus.card_out}, 32'd1);
    check("cancel_no_error", {29'd0, bus.err_code}, 32'd0);
    remove_card();
    check("eject_release", {31'd0, bus.card_out}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Three wrong PINs lock the account.
    insert(6'd2);
    expect_ev(3'b001, 3'd0, '0, 1'b0);
    enter_pin(16'h0000);
    expect_ev(3'b001, 3'd0, '0, 1'b0);
    enter_pin(16'h0000);
    expect_ev(3'b011, 3'd2, '0, 1'b0);
    enter_pin(16'h0000);
    check("lockout_card_out", {31'd0, bus.card_out}, 32'd1);
    remove_card();
    // Out-of-range table write must not alias onto entry 2 and unlock it.
    cfg_write(6'd10, 16'h1234, 20'd5);
    expect_ev(3'b010, 3'd2, '0, 1'b0);
    insert(6'd2);
    idle(1);
    check("locked_reinsert_eject", {31'd0, bus.card_out}, 32'd1);
    remove_card();

    // Invalid card index.
    expect_ev(3'b010, 3'd1, '0, 1'b0);
    insert(6'd9);
    idle(1);
    check("invalid_card_out", {31'd0, bus.card_out}, 32'd1);
    check("invalid_err_code", {29'd0, bus.err_code}, 32'd1);
    enter_pin(16'h0000);
    remove_card();

    // Balance boundary cases.
    cfg_write(6'd3, 16'h1111, 20'd1000);
    cfg_write(6'd4, 16'h2222, 20'hFFFF0);
    insert(6'd3);
    enter_pin(16'h1111);
    expect_ev(3'b010, 3'd4, 20'd1000, 1'b1);
    do_op(2'b01, 20'd1500);
    check("insufficient_balance_out", {12'd0, bus.balance_out}, 32'd1000);
    press_another();
    expect_ev(3'b100, 3'd0, 20'd1000, 1'b1);
    do_op(2'b00, 20'd0);
    press_another();
    expect_ev(3'b010, 3'd7, 20'd1000, 1'b1);
    do_op(2'b11, 20'd5);
    press_another();
    expect_ev(3'b100, 3'd0, 20'd1500, 1'b1);
    do_op(2'b10, 20'd500);
    press_cancel();
    remove_card();
    insert(6'd4);
    enter_pin(16'h2222);
    expect_ev(3'b010, 3'd5, 20'hFFFF0, 1'b1);
    do_op(2'b10, 20'h20);
    press_another();
    expect_ev(3'b100, 3'd0, 20'hFFFFF, 1'b1);
    do_op(2'b10, 20'h0F);
    press_cancel();
    remove_card();

    // Per-session withdrawal cap (or plain balance check without it).
    cfg_write(6'd5, 16'h5555, 20'd9000);
    insert(6'd5);
    enter_pin(16'h5555);
    expect_ev(3'b100, 3'd0, 20'd6000, 1'b1);
    do_op(2'b01, 20'd3000);
    press_another();
`ifdef ATM_DAILY_LIMIT_EN
    expect_ev(3'b010, 3'd6, 20'd6000, 1'b1);
`else
    expect_ev(3'b100, 3'd0, 20'd3500, 1'b1);
`endif
    do_op(2'b01, 20'd2500);
    press_cancel();
    remove_card();

    // Inactivity timeout in MENU.
    insert(6'd3);
    enter_pin(16'h1111);
    expect_ev(3'b010, 3'd3, '0, 1'b0);
    n = 0;
    while (n < 2 * TO) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.error) break;
    end
    check("timeout_cycle", n, TO);
    idle(1);
    check("timeout_card_out", {31'd0, bus.card_out}, 32'd1);
    remove_card();

    // Cancel beats op_valid; cfg writes outside IDLE are ignored.
    insert(6'd3);
    enter_pin(16'h1111);
    cfg_write(6'd3, 16'h0000, 20'd0);
    @(negedge clk);
    bus.cancel = 1'b1; bus.op_valid = 1'b1; bus.op = 2'b01; bus.amount = 20'd10;
    @(negedge clk);
    bus.cancel = 1'b0; bus.op_valid = 1'b0;
    check("cancel_priority_card_out", {31'd0, bus.card_out}, 32'd1);
    idle(3);
    remove_card();
    insert(6'd3);
    enter_pin(16'h1111);
    expect_ev(3'b100, 3'd0, 20'd1500, 1'b1);
    do_op(2'b00, 20'd0);
    press_cancel();
    remove_card();

    idle(3);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/atm_session_engine.md
Name: atm_session_engine

Overview:
- Parametrised next-generation ATM transaction core with an on-chip account table of ACCOUNTS entries, each holding PIN, balance and lock bit.
- Runs a full card session: card accept, PIN check with retry lockout, service loop, card eject.
- Has an internal inactivity timer.
- Sits under the ATM top level in place of the separate FSM/card-handling/timer split; the user-interface block drives pin_valid/op_valid.

Parameters:
- P_WIDTH, 16, PIN width
- B_WIDTH, 20, balance/amount width
- C_WIDTH, 6, card number width
- ACCOUNTS, 8, account table depth (must be <= 2**C_WIDTH)
- MAX_TRIES, 3, wrong PINs before account lock
- TIMEOUT_CYCLES, 1000, inactivity cycles before forced eject
- DAILY_LIMIT, 5000, per-session withdrawal cap (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- card_in  in  1  card present level
- card_number  in  C_WIDTH  card id, sampled on session start
- pin_valid  in  1  one-cycle strobe, pin_in valid
- pin_in  in  P_WIDTH  entered PIN
- op_valid  in  1  one-cycle strobe, op/amount valid
- op  in  2  00 balance, 01 withdraw, 10 deposit, 11 reserved
- amount  in  B_WIDTH  withdraw/deposit value
- another_service  in  1  continue session
- cancel  in  1  end session
- cfg_we  in  1  account table write
- cfg_addr  in  C_WIDTH  table index
- cfg_pin  in  P_WIDTH  PIN to store
- cfg_balance  in  B_WIDTH  balance to store
- card_out  out  1  eject request level
- balance_out  out  B_WIDTH  balance after last service
- op_done  out  1  one-cycle success pulse
- error  out  1  one-cycle error pulse
- err_code  out  3  0 none, 1 invalid card, 2 locked, 3 timeout, 4 insufficient, 5 overflow, 6 limit, 7 bad op
- wrong_password  out  1  one-cycle pulse per wrong PIN
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; table PINs, balances and lock bits 0; try counter, timer and session-withdraw accumulator 0.
- States: IDLE, PIN, MENU, EXEC, ASK, EJECT.
- IDLE:
  - cfg_we writes the entry and clears its lock bit.
  - cfg_we outside IDLE is ignored; cfg_addr >= ACCOUNTS is ignored.
  - card_in=1 latches card_number.
  - Index >= ACCOUNTS -> error, err_code=1, go EJECT. Locked entry -> error, err_code=2, go EJECT. Otherwise go PIN, tries=0.
- PIN:
  - pin_valid with match -> MENU.
  - Mismatch -> wrong_password pulse, tries+1.
  - If tries reaches MAX_TRIES -> set lock bit, error with err_code=2, go EJECT.
- MENU:
  - op_valid latches op and amount, go EXEC.
- EXEC (exactly one cycle, then ASK):
  - Balance: op_done.
  - Withdraw with amount > balance: err 4. Otherwise subtract.
  - Deposit with sum > 2**B_WIDTH-1: err 5. Otherwise add; sum is computed B_WIDTH+1 wide.
  - op=11: err 7.
  - On error the balance is unchanged.
  - balance_out always shows the resulting stored balance, registered and updated the same cycle as op_done/error.
- ASK:
  - another_service -> MENU.
  - cancel -> EJECT.
- Cancel in PIN, MENU or ASK -> EJECT with no error.
- Timer:
  - Counts in PIN, MENU and ASK; cleared on every state change and on any accepted strobe.
  - Reaching TIMEOUT_CYCLES-1 -> error, err_code=3, go EJECT.
- Same-cycle priority: cancel > valid strobe/another_service > timeout.
- EJECT: card_out=1 held until card_in=0, then IDLE with card_out=0. Session accumulator and tries are cleared on entering IDLE.
- err_code holds its last value until the next error or session start (cleared to 0 on IDLE->PIN).
- Strobes are ignored in states that do not consume them.

Optional Feature:
- Macro ATM_DAILY_LIMIT_EN.
- Defined: withdraw also fails with err 6 if accumulator+amount > DAILY_LIMIT; a successful withdraw adds amount to the accumulator. The err 4 check has priority over err 6.
- Undefined: no accumulator is built; withdraw is limited only by balance and err 6 is never produced.

Test Plan:
- cfg entry 2 (pin 0x1234, bal 1000); card 2; pin 0x1234; withdraw 300 -> op_done, balance_out=700; cancel -> card_out=1 until card_in=0.
- Card 2, three pins of 0x0000 -> three wrong_password pulses, error err_code=2 on the third. Reinsert card 2 -> immediate err 2 and eject.
- Card 9 with ACCOUNTS=8 -> error err_code=1, card_out=1, never PIN.
- Balance 1000: withdraw 1500 -> err 4, balance_out=1000. Balance 0xFFFF0: deposit 0x20 -> err 5.
- PIN accepted, then no input for TIMEOUT_CYCLES -> err 3 at cycle TIMEOUT_CYCLES-1, eject. Cancel and op_valid in the same cycle -> EJECT, no op_done.
- With ATM_DAILY_LIMIT_EN, balance 9000: withdraw 3000 ok, then withdraw 2500 -> err 6, balance_out=6000.
